gobou_layer_seq: RTL and testbench

Layer sequencer for the gobou fully-connected core controller. The host writes a descriptor table of up to MAXLAYER layers, then pulses start. The block issues one req/ack transaction per layer to the core controller, driving that layer's sizes and base addresses, until all layers are done. It sits between the ninjin host register interface and the gobou core control.

---
 rtl/gobou_layer_seq_pkg.sv | 23 ++
 rtl/gobou_layer_table.sv | 58 +++++
 rtl/gobou_layer_seq.sv | 195 +++++++++++++++++++
 tb/tb_gobou_layer_seq.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gobou_layer_seq_pkg.sv
// Shared definitions for the gobou layer sequencer: table geometry,
// descriptor field codes (also used by the ninjin register map) and FSM states.
package gobou_layer_seq_pkg;

    localparam int unsigned MAXLAYER = 8;
    localparam int unsigned LAYERLOG = 3;

    localparam logic [2:0] FIELD_TOTAL_IN    = 3'd0;
    localparam logic [2:0] FIELD_TOTAL_OUT   = 3'd1;
    localparam logic [2:0] FIELD_INPUT_ADDR  = 3'd2;
    localparam logic [2:0] FIELD_OUTPUT_ADDR = 3'd3;
    localparam logic [2:0] FIELD_NET_ADDR    = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StWaitLow,
        StWaitHigh,
        StNext
    } seq_state_e;

endpackage

// File: rtl/gobou_layer_table.sv
// Descriptor register file: one write port (field-addressed) and one
// combinational read port returning every field of the selected layer.
module gobou_layer_table
    import gobou_layer_seq_pkg::*;
#(
    parameter int unsigned LWIDTH        = 16,
    parameter int unsigned IMGSIZE       = 12,
    parameter int unsigned GOBOU_NETSIZE = 11
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     we,
    input  logic [LAYERLOG-1:0]      wr_layer,
    input  logic [2:0]               wr_field,
    input  logic [LWIDTH-1:0]        wr_data,
    input  logic [LAYERLOG-1:0]      rd_layer,
    output logic [LWIDTH-1:0]        rd_total_in,
    output logic [LWIDTH-1:0]        rd_total_out,
    output logic [IMGSIZE-1:0]       rd_input_addr,
    output logic [IMGSIZE-1:0]       rd_output_addr,
    output logic [GOBOU_NETSIZE-1:0] rd_net_addr
);

    logic [LWIDTH-1:0]        total_in_q    [MAXLAYER];
    logic [LWIDTH-1:0]        total_out_q   [MAXLAYER];
    logic [IMGSIZE-1:0]       input_addr_q  [MAXLAYER];
    logic [IMGSIZE-1:0]       output_addr_q [MAXLAYER];
    logic [GOBOU_NETSIZE-1:0] net_addr_q    [MAXLAYER];

    // Field write; data is truncated to the field width, codes 5-7 are dropped.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < MAXLAYER; i++) begin
                total_in_q[i]    <= '0;
                total_out_q[i]   <= '0;
                input_addr_q[i]  <= '0;
                output_addr_q[i] <= '0;
                net_addr_q[i]    <= '0;
            end
        end else if (we) begin
            case (wr_field)
                FIELD_TOTAL_IN:    total_in_q[wr_layer]    <= wr_data;
                FIELD_TOTAL_OUT:   total_out_q[wr_layer]   <= wr_data;
                FIELD_INPUT_ADDR:  input_addr_q[wr_layer]  <= wr_data[IMGSIZE-1:0];
                FIELD_OUTPUT_ADDR: output_addr_q[wr_layer] <= wr_data[IMGSIZE-1:0];
                FIELD_NET_ADDR:    net_addr_q[wr_layer]    <= wr_data[GOBOU_NETSIZE-1:0];
                default: ;
            endcase
        end
    end

    assign rd_total_in    = total_in_q[rd_layer];
    assign rd_total_out   = total_out_q[rd_layer];
    assign rd_input_addr  = input_addr_q[rd_layer];
    assign rd_output_addr = output_addr_q[rd_layer];
    assign rd_net_addr    = net_addr_q[rd_layer];

endmodule

// File: rtl/gobou_layer_seq.sv
// Layer sequencer: walks the descriptor table and issues one req/ack
// transaction per layer to the gobou core controller.
module gobou_layer_seq
    import gobou_layer_seq_pkg::*;
#(
    parameter int unsigned LWIDTH        = 16,
    parameter int unsigned IMGSIZE       = 12,
    parameter int unsigned GOBOU_NETSIZE = 11
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     cfg_we,
    input  logic [LAYERLOG-1:0]      cfg_layer,
    input  logic [2:0]               cfg_field,
    input  logic [LWIDTH-1:0]        cfg_data,
    input  logic [LAYERLOG:0]        num_layers,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     skip_err,
    output logic [LAYERLOG-1:0]      layer_idx,
    output logic                     core_req,
    input  logic                     core_ack,
    output logic [LWIDTH-1:0]        core_total_in,
    output logic [LWIDTH-1:0]        core_total_out,
    output logic [IMGSIZE-1:0]       core_input_addr,
    output logic [IMGSIZE-1:0]       core_output_addr,
    output logic [GOBOU_NETSIZE-1:0] core_net_addr
);

    localparam logic [LAYERLOG:0] MaxLayers = (LAYERLOG + 1)'(MAXLAYER);
    localparam logic [LAYERLOG:0] OneLayer  = (LAYERLOG + 1)'(1);

    seq_state_e state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     skip_err_q, skip_err_d;
    logic                     abort_q, abort_d;
    logic                     core_req_q, core_req_d;
    logic [LAYERLOG-1:0]      layer_idx_q, layer_idx_d;
    logic [LAYERLOG:0]        num_q, num_d;
    logic [LWIDTH-1:0]        total_in_q, total_in_d, total_out_q, total_out_d;
    logic [IMGSIZE-1:0]       input_addr_q, input_addr_d, output_addr_q, output_addr_d;
    logic [GOBOU_NETSIZE-1:0] net_addr_q, net_addr_d;

    logic [LWIDTH-1:0]        tbl_total_in, tbl_total_out;
    logic [IMGSIZE-1:0]       tbl_input_addr, tbl_output_addr;
    logic [GOBOU_NETSIZE-1:0] tbl_net_addr;

    gobou_layer_table #(
        .LWIDTH        (LWIDTH),
        .IMGSIZE       (IMGSIZE),
        .GOBOU_NETSIZE (GOBOU_NETSIZE)
    ) u_table (
        .clk            (clk),
        .xrst           (xrst),
        .we             (cfg_we),
        .wr_layer       (cfg_layer),
        .wr_field       (cfg_field),
        .wr_data        (cfg_data),
        .rd_layer       (layer_idx_q),
        .rd_total_in    (tbl_total_in),
        .rd_total_out   (tbl_total_out),
        .rd_input_addr  (tbl_input_addr),
        .rd_output_addr (tbl_output_addr),
        .rd_net_addr    (tbl_net_addr)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        skip_err_d    = skip_err_q;
        abort_d       = abort_q;
        core_req_d    = 1'b0;
        layer_idx_d   = layer_idx_q;
        num_d         = num_q;
        total_in_d    = total_in_q;
        total_out_d   = total_out_q;
        input_addr_d  = input_addr_q;
        output_addr_d = output_addr_q;
        net_addr_d    = net_addr_q;

        // Abort is remembered until the run ends so an in-flight transaction completes.
        if (state_q != StIdle && abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                abort_d = 1'b0;
                if (start) begin
                    if (num_layers != '0) begin
                        busy_d      = 1'b1;
                        layer_idx_d = '0;
                        skip_err_d  = 1'b0;
                        num_d       = (num_layers > MaxLayers) ? MaxLayers : num_layers;
                        state_d     = StLoad;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                total_in_d    = tbl_total_in;
                total_out_d   = tbl_total_out;
                input_addr_d  = tbl_input_addr;
                output_addr_d = tbl_output_addr;
                net_addr_d    = tbl_net_addr;
                if (tbl_total_in == '0 || tbl_total_out == '0) begin
                    skip_err_d = 1'b1;
                    state_d    = StNext;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Only request when the core reports idle.
                if (core_ack) begin
                    core_req_d = 1'b1;
                    state_d    = StWaitLow;
                end
            end
            StWaitLow: begin
                if (!core_ack) begin
                    state_d = StWaitHigh;
                end
            end
            StWaitHigh: begin
                if (core_ack) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (({1'b0, layer_idx_q} == num_q - OneLayer) || abort_q || abort) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    abort_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    layer_idx_d = layer_idx_q + LAYERLOG'(1);
                    state_d     = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            skip_err_q    <= 1'b0;
            abort_q       <= 1'b0;
            core_req_q    <= 1'b0;
            layer_idx_q   <= '0;
            num_q         <= '0;
            total_in_q    <= '0;
            total_out_q   <= '0;
            input_addr_q  <= '0;
            output_addr_q <= '0;
            net_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            skip_err_q    <= skip_err_d;
            abort_q       <= abort_d;
            core_req_q    <= core_req_d;
            layer_idx_q   <= layer_idx_d;
            num_q         <= num_d;
            total_in_q    <= total_in_d;
            total_out_q   <= total_out_d;
            input_addr_q  <= input_addr_d;
            output_addr_q <= output_addr_d;
            net_addr_q    <= net_addr_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign skip_err         = skip_err_q;
    assign layer_idx        = layer_idx_q;
    assign core_req         = core_req_q;
    assign core_total_in    = total_in_q;
    assign core_total_out   = total_out_q;
    assign core_input_addr  = input_addr_q;
    assign core_output_addr = output_addr_q;
    assign core_net_addr    = net_addr_q;

endmodule

// File: tb/tb_gobou_layer_seq.sv
// Directed bench for gobou_layer_seq with a simple core model that drops ack
// for a fixed number of cycles after each request.
module tb_gobou_layer_seq;

    localparam int HOLD = 20;

    logic        clk = 1'b0;
    logic        xrst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_layer = '0;
    logic [2:0]  cfg_field = '0;
    logic [15:0] cfg_data = '0;
    logic [3:0]  num_layers = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        core_ack = 1'b1;
    logic        busy, done, skip_err, core_req;
    logic [2:0]  layer_idx;
    logic [15:0] core_total_in, core_total_out;
    logic [11:0] core_input_addr, core_output_addr;
    logic [10:0] core_net_addr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;

    // Core-model observations, cumulative over the whole run.
    int          req_count = 0;
    int          done_count = 0;
    int          done_cyc = 0;
    int          busy_cnt = 0;
    int          hold = 0;
    int          req_cyc  [32];
    int          rise_cyc [32];
    logic [15:0] req_ti   [32];
    logic [15:0] req_to   [32];
    logic [11:0] req_ia   [32];
    logic [11:0] req_oa   [32];
    logic [10:0] req_na   [32];

    gobou_layer_seq dut (
        .clk              (clk),
        .xrst             (xrst),
        .cfg_we           (cfg_we),
        .cfg_layer        (cfg_layer),
        .cfg_field        (cfg_field),
        .cfg_data         (cfg_data),
        .num_layers       (num_layers),
        .start            (start),
        .abort            (abort),
        .busy             (busy),
        .done             (done),
        .skip_err         (skip_err),
        .layer_idx        (layer_idx),
        .core_req         (core_req),
        .core_ack         (core_ack),
        .core_total_in    (core_total_in),
        .core_total_out   (core_total_out),
        .core_input_addr  (core_input_addr),
        .core_output_addr (core_output_addr),
        .core_net_addr    (core_net_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model and monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        if (!xrst) begin
            core_ack = 1'b1;
            hold     = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (core_req) begin
                if (req_count < 32) begin
                    req_cyc[req_count] = cyc;
                    req_ti[req_count]  = core_total_in;
                    req_to[req_count]  = core_total_out;
                    req_ia[req_count]  = core_input_addr;
                    req_oa[req_count]  = core_output_addr;
                    req_na[req_count]  = core_net_addr;
                end
                req_count++;
                core_ack = 1'b0;
                hold     = HOLD;
            end else if (!core_ack) begin
                hold--;
                if (hold == 0) begin
                    core_ack = 1'b1;
                    if (req_count >= 1 && req_count <= 32) rise_cyc[req_count-1] = cyc;
                end
            end
        end
    end

    task automatic cfg_write(input int layer, input int field, input int data);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_layer = 3'(layer);
        cfg_field = 3'(field);
        cfg_data  = 16'(data);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic set_layer(input int l, input int ti, input int to, input int ia,
                             input int oa, input int na);
        cfg_write(l, 0, ti);
        cfg_write(l, 1, to);
        cfg_write(l, 2, ia);
        cfg_write(l, 3, oa);
        cfg_write(l, 4, na);
    endtask

    task automatic run_start(input int n);
        @(negedge clk);
        start      = 1'b1;
        num_layers = 4'(n);
        start_cyc  = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (done_count > base) ok = 1'b1;
        end
    endtask

    task automatic wait_req(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (req_count >= target) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, skip_err, core_req, layer_idx} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%0h exp=0", {busy, done, skip_err, core_req, layer_idx});
        end
        checks++;
        if ({core_total_in, core_total_out} !== 32'd0) begin
            failures++;
            $display("FAIL reset_sizes got=%0h exp=0", {core_total_in, core_total_out});
        end
        checks++;
        if ({core_input_addr, core_output_addr, core_net_addr} !== 35'd0) begin
            failures++;
            $display("FAIL reset_addrs got=%0h exp=0",
                     {core_input_addr, core_output_addr, core_net_addr});
        end
        #2 xrst = 1'b1;
    endtask

    task automatic test_two_layers();
        int rb, db;
        bit ok;
        set_layer(0, 4, 32, 'h000, 'h100, 'h000);
        set_layer(1, 32, 10, 'h100, 'h200, 'h080);
        rb = req_count;
        db = done_count;
        run_start(2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL two_busy_after_start got=%0b exp=1", busy);
        end
        wait_done(db, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL two_done_timeout got=%0d exp=%0d", done_count, db + 1);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (req_count - rb !== 2) begin
            failures++;
            $display("FAIL two_req_count got=%0d exp=2", req_count - rb);
        end
        checks++;
        if (req_cyc[rb] - start_cyc !== 3) begin
            failures++;
            $display("FAIL two_req_latency got=%0d exp=3", req_cyc[rb] - start_cyc);
        end
        checks++;
        if ({req_ti[rb], req_to[rb], req_ia[rb], req_oa[rb], req_na[rb]} !==
            {16'd4, 16'd32, 12'h000, 12'h100, 11'h000}) begin
            failures++;
            $display("FAIL two_l0_fields got=%0h/%0h/%0h/%0h/%0h exp=4/20/0/100/0",
                     req_ti[rb], req_to[rb], req_ia[rb], req_oa[rb], req_na[rb]);
        end
        checks++;
        if ({req_ti[rb+1], req_to[rb+1], req_ia[rb+1], req_oa[rb+1], req_na[rb+1]} !==
            {16'd32, 16'd10, 12'h100, 12'h200, 11'h080}) begin
            failures++;
            $display("FAIL two_l1_fields got=%0h/%0h/%0h/%0h/%0h exp=20/a/100/200/80",
                     req_ti[rb+1], req_to[rb+1], req_ia[rb+1], req_oa[rb+1], req_na[rb+1]);
        end
        checks++;
        if (req_cyc[rb+1] - rise_cyc[rb] !== 4) begin
            failures++;
            $display("FAIL two_ack_to_req got=%0d exp=4", req_cyc[rb+1] - rise_cyc[rb]);
        end
        checks++;
        if (done_count - db !== 1) begin
            failures++;
            $display("FAIL two_done_pulses got=%0d exp=1", done_count - db);
        end
        checks++;
        if ({busy, skip_err, layer_idx} !== 5'b0_0_001) begin
            failures++;
            $display("FAIL two_end_state got=%0b exp=00001", {busy, skip_err, layer_idx});
        end
    endtask

    task automatic test_zero_layers();
        int rb, db, bc;
        rb = req_count;
        db = done_count;
        bc = busy_cnt;
        run_start(0);
        repeat (5) @(negedge clk);
        checks++;
        if (done_count - db !== 1) begin
            failures++;
            $display("FAIL zero_done_pulses got=%0d exp=1", done_count - db);
        end
        checks++;
        if (done_cyc - start_cyc !== 1) begin
            failures++;
            $display("FAIL zero_done_latency got=%0d exp=1", done_cyc - start_cyc);
        end
        checks++;
        if (req_count - rb !== 0) begin
            failures++;
            $display("FAIL zero_no_req got=%0d exp=0", req_count - rb);
        end
        checks++;
        if (busy_cnt - bc !== 0) begin
            failures++;
            $display("FAIL zero_busy_cycles got=%0d exp=0", busy_cnt - bc);
        end
    endtask

    task automatic test_skip();
        int rb, db;
        bit ok;
        cfg_write(1, 1, 0);
        set_layer(2, 8, 16, 'h300, 'h400, 'h100);
        rb = req_count;
        db = done_count;
        run_start(3);
        wait_done(db, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL skip_done_timeout got=%0d exp=%0d", done_count, db + 1);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (req_count - rb !== 2) begin
            failures++;
            $display("FAIL skip_req_count got=%0d exp=2", req_count - rb);
        end
        checks++;
        if (req_ti[rb] !== 16'd4) begin
            failures++;
            $display("FAIL skip_first_is_l0 got=%0d exp=4", req_ti[rb]);
        end
        checks++;
        if ({req_ti[rb+1], req_oa[rb+1], req_na[rb+1]} !== {16'd8, 12'h400, 11'h100}) begin
            failures++;
            $display("FAIL skip_second_is_l2 got=%0h/%0h/%0h exp=8/400/100",
                     req_ti[rb+1], req_oa[rb+1], req_na[rb+1]);
        end
        checks++;
        if (skip_err !== 1'b1) begin
            failures++;
            $display("FAIL skip_err_flag got=%0b exp=1", skip_err);
        end
        checks++;
        if ({busy, layer_idx} !== 4'b0_010) begin
            failures++;
            $display("FAIL skip_end_state got=%0b exp=0010", {busy, layer_idx});
        end
    endtask

    task automatic test_abort();
        int rb, db;
        bit ok;
        cfg_write(1, 1, 10);
        rb = req_count;
        db = done_count;
        run_start(3);
        checks++;
        if (skip_err !== 1'b0) begin
            failures++;
            $display("FAIL abort_skip_cleared got=%0b exp=0", skip_err);
        end
        wait_req(rb + 1, ok);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(db, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL abort_done_timeout got=%0d exp=%0d", done_count, db + 1);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (req_count - rb !== 1) begin
            failures++;
            $display("FAIL abort_req_count got=%0d exp=1", req_count - rb);
        end
        checks++;
        if (done_cyc - rise_cyc[rb] !== 2) begin
            failures++;
            $display("FAIL abort_done_latency got=%0d exp=2", done_cyc - rise_cyc[rb]);
        end
        checks++;
        if ({busy, layer_idx} !== 4'b0_000) begin
            failures++;
            $display("FAIL abort_end_state got=%0b exp=0000", {busy, layer_idx});
        end
    endtask

    task automatic test_midrun_write();
        int rb, db;
        bit ok;
        rb = req_count;
        db = done_count;
        run_start(2);
        wait_req(rb + 1, ok);
        cfg_write(1, 0, 64);
        cfg_write(0, 0, 99);
        @(negedge clk);
        checks++;
        if (core_total_in !== 16'd4) begin
            failures++;
            $display("FAIL midrun_l0_stable got=%0d exp=4", core_total_in);
        end
        wait_done(db, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midrun_done_timeout got=%0d exp=%0d", done_count, db + 1);
        end
        checks++;
        if (req_ti[rb] !== 16'd4) begin
            failures++;
            $display("FAIL midrun_l0_issued got=%0d exp=4", req_ti[rb]);
        end
        checks++;
        if (req_ti[rb+1] !== 16'd64) begin
            failures++;
            $display("FAIL midrun_l1_new_value got=%0d exp=64", req_ti[rb+1]);
        end
    endtask

    task automatic test_async_reset();
        int rb, db;
        bit ok;
        rb = req_count;
        run_start(1);
        wait_req(rb + 1, ok);
        repeat (4) @(negedge clk);
        #2 xrst = 1'b0;
        #1;
        checks++;
        if ({busy, done, skip_err, core_req, layer_idx} !== 7'd0) begin
            failures++;
            $display("FAIL arst_ctrl got=%0h exp=0", {busy, done, skip_err, core_req, layer_idx});
        end
        checks++;
        if ({core_total_in, core_total_out, core_input_addr, core_output_addr,
             core_net_addr} !== 67'd0) begin
            failures++;
            $display("FAIL arst_fields got=%0h/%0h/%0h/%0h/%0h exp=0", core_total_in,
                     core_total_out, core_input_addr, core_output_addr, core_net_addr);
        end
        repeat (2) @(negedge clk);
        #2 xrst = 1'b1;
        // Table was cleared, so a one-layer run must skip.
        rb = req_count;
        db = done_count;
        run_start(1);
        wait_done(db, ok);
        repeat (2) @(negedge clk);
        checks++;
        if ({ok, skip_err} !== 2'b11 || req_count != rb) begin
            failures++;
            $display("FAIL arst_table_cleared got=%0b%0b reqs=%0d exp=11 reqs=0", ok, skip_err,
                     req_count - rb);
        end
        set_layer(0, 5, 7, 'h010, 'h020, 'h030);
        rb = req_count;
        db = done_count;
        run_start(1);
        wait_done(db, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || req_count - rb !== 1) begin
            failures++;
            $display("FAIL arst_fresh_run got=%0d reqs exp=1", req_count - rb);
        end
        checks++;
        if ({req_ti[rb], req_to[rb], req_ia[rb], req_oa[rb], req_na[rb]} !==
            {16'd5, 16'd7, 12'h010, 12'h020, 11'h030}) begin
            failures++;
            $display("FAIL arst_fresh_fields got=%0h/%0h/%0h/%0h/%0h exp=5/7/10/20/30",
                     req_ti[rb], req_to[rb], req_ia[rb], req_oa[rb], req_na[rb]);
        end
        checks++;
        if (req_cyc[rb] - start_cyc !== 3 || skip_err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL arst_fresh_timing got=%0d skip=%0b busy=%0b exp=3 skip=0 busy=0",
                     req_cyc[rb] - start_cyc, skip_err, busy);
        end
    endtask

    initial begin
        test_reset();
        test_two_layers();
        test_zero_layers();
        test_skip();
        test_abort();
        test_midrun_write();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
